spi_shift: RTL and testbench

- Serial data engine of the SPI master.
- Sits directly downstream of the SPI clock generator:
  - consumes its rising-edge strobe (pos_edge) and falling-edge strobe (neg_edge);
  - returns tip and last, which gate the clock generator.
- Holds one TX character, drives MOSI and samples MISO on the selected edges.
- Presents the received character in parallel to the Wishbone register block.

---
 rtl/spi_defs.sv | 23 ++
 rtl/spi_edge_sel.sv | 15 +
 rtl/spi_shift.sv | 101 ++++++++++
 tb/tb_spi_shift.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_defs.sv
// Shared definitions for the SPI master: character sizing, shift-engine
// state encoding and the bit-order index helper.
package spi_defs;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 5;
    localparam int CNT_W  = LEN_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Position of the k-th transferred bit inside an n-bit character.
    function automatic logic [LEN_W-1:0] idx(input logic [CNT_W-1:0] k,
                                             input logic [CNT_W-1:0] n,
                                             input logic             lsb_first);
        logic [CNT_W-1:0] t;
        t = lsb_first ? k : (n - CNT_W'(1) - k);
        return t[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/spi_edge_sel.sv
// Routes the clock generator's edge strobes to the transmit and receive
// paths according to the configured SPI mode.
module spi_edge_sel (
    input  logic tx_negedge,
    input  logic rx_negedge,
    input  logic pos_edge,
    input  logic neg_edge,
    output logic tx_edge,
    output logic rx_edge
);

    assign tx_edge = tx_negedge ? neg_edge : pos_edge;
    assign rx_edge = rx_negedge ? neg_edge : pos_edge;

endmodule

// File: rtl/spi_shift.sv
// SPI master serial data engine: shifts one character out on MOSI and in
// from MISO.  States: ST_IDLE | waiting for go ; ST_XFER | shifting.
module spi_shift
    import spi_defs::*;
(
    input  logic              wb_clk,
    input  logic              wb_reset,
    input  logic              go,
    input  logic [LEN_W-1:0]  len,
    input  logic              lsb,
    input  logic              tx_negedge,
    input  logic              rx_negedge,
    input  logic              pos_edge,
    input  logic              neg_edge,
    input  logic              latch,
    input  logic [DATA_W-1:0] p_in,
    input  logic              s_in,
    output logic              s_out,
    output logic [DATA_W-1:0] p_out,
    output logic              tip,
    output logic              last,
    output logic              done
);

    state_t            state, state_nx;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] tx_src;
    logic [CNT_W-1:0]  n_q, n_new, tx_cnt, rx_cnt;
    logic              tx_edge, rx_edge, rx_final;

    spi_edge_sel u_edge_sel (
        .tx_negedge (tx_negedge),
        .rx_negedge (rx_negedge),
        .pos_edge   (pos_edge),
        .neg_edge   (neg_edge),
        .tx_edge    (tx_edge),
        .rx_edge    (rx_edge)
    );

    assign n_new    = (len == '0) ? CNT_W'(DATA_W) : {1'b0, len};
    // A latch coinciding with go must already drive the first bit.
    assign tx_src   = latch ? p_in : shadow;
    assign rx_final = (rx_cnt == n_q - CNT_W'(1));
    assign last     = tip & rx_final;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (go) state_nx = ST_XFER;
            ST_XFER: if (rx_edge && rx_final) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_reset) begin
            state  <= ST_IDLE;
            s_out  <= 1'b0;
            p_out  <= '0;
            tip    <= 1'b0;
            done   <= 1'b0;
            shadow <= '0;
            n_q    <= '0;
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (latch) shadow <= p_in;
                    if (go) begin
                        tip    <= 1'b1;
                        n_q    <= n_new;
                        p_out  <= '0;
                        tx_cnt <= CNT_W'(1);
                        rx_cnt <= '0;
                        s_out  <= tx_src[idx('0, n_new, lsb)];
                    end
                end
                ST_XFER: begin
                    if (rx_edge) begin
                        p_out[idx(rx_cnt, n_q, lsb)] <= s_in;
                        rx_cnt <= rx_cnt + CNT_W'(1);
                        if (rx_final) begin
                            tip  <= 1'b0;
                            done <= 1'b1;
                        end
                    end
                    // Saturate after the final bit so s_out never wraps.
                    if (tx_edge && (tx_cnt < n_q)) begin
                        s_out  <= shadow[idx(tx_cnt, n_q, lsb)];
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift.sv
// Directed-vector bench for spi_shift: drives the edge strobes the clock
// generator would produce and checks serial/parallel data against hand values.
module tb_spi_shift;
    import spi_defs::*;

    logic              wb_clk = 1'b0;
    logic              wb_reset = 1'b1;
    logic              go = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic              lsb = 1'b0;
    logic              tx_negedge = 1'b0;
    logic              rx_negedge = 1'b0;
    logic              pos_edge = 1'b0;
    logic              neg_edge = 1'b0;
    logic              latch = 1'b0;
    logic [DATA_W-1:0] p_in = '0;
    logic              s_in;
    logic              s_out;
    logic [DATA_W-1:0] p_out;
    logic              tip;
    logic              last;
    logic              done;

    logic loop_en = 1'b1;
    logic s_hold  = 1'b0;
    assign s_in = loop_en ? s_out : s_hold;

    spi_shift dut (
        .wb_clk     (wb_clk),
        .wb_reset   (wb_reset),
        .go         (go),
        .len        (len),
        .lsb        (lsb),
        .tx_negedge (tx_negedge),
        .rx_negedge (rx_negedge),
        .pos_edge   (pos_edge),
        .neg_edge   (neg_edge),
        .latch      (latch),
        .p_in       (p_in),
        .s_in       (s_in),
        .s_out      (s_out),
        .p_out      (p_out),
        .tip        (tip),
        .last       (last),
        .done       (done)
    );

    always #5 wb_clk = ~wb_clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [63:0] cap;
    int          rxc, pos_tip, done_cnt, last_bad;
    bit          finished;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [31:0] d);
        @(negedge wb_clk);
        p_in  = d;
        latch = 1'b1;
        @(negedge wb_clk);
        latch = 1'b0;
    endtask

    // Issues go, then alternating pos/neg strobes (pos first, 3 idle cycles
    // between).  Records s_out at every rx strobe, MSB of cap = first bit.
    task automatic run_xfer(input int n, input bit lsb_i, input bit txn, input bit rxn,
                            input bit same_latch, input logic [31:0] data,
                            input int inject_at, input int abort_rx);
        bit is_pos, is_rx;
        @(negedge wb_clk);
        tx_negedge = txn;
        rx_negedge = rxn;
        lsb        = lsb_i;
        len        = (n == 32) ? 5'd0 : 5'(n);
        if (same_latch) begin
            p_in  = data;
            latch = 1'b1;
        end
        go = 1'b1;
        @(negedge wb_clk);
        go    = 1'b0;
        latch = 1'b0;
        cap = '0; rxc = 0; pos_tip = 0; done_cnt = 0; last_bad = 0; finished = 0;
        for (int i = 0; i < 2*n + 4 && !finished; i++) begin
            is_pos   = (i % 2) == 0;
            pos_edge = is_pos;
            neg_edge = !is_pos;
            is_rx    = rxn ? !is_pos : is_pos;
            #1;
            if (last !== (rxc == n - 1)) last_bad++;
            if (tip && is_pos) pos_tip++;
            if (tip && is_rx) begin
                cap = {cap[62:0], s_out};
                rxc++;
            end
            @(negedge wb_clk);
            pos_edge = 1'b0;
            neg_edge = 1'b0;
            if (done) done_cnt++;
            if (abort_rx != 0 && rxc == abort_rx) begin
                check_vec("abort_p_out_partial", p_out, 64'hA0);
                check_vec("abort_s_out_before", s_out, 1);
                wb_reset = 1'b1;
                @(negedge wb_clk);
                wb_reset = 1'b0;
                check_vec("abort_tip", tip, 0);
                check_vec("abort_s_out", s_out, 0);
                check_vec("abort_p_out", p_out, 0);
                check_vec("abort_done", done, 0);
                repeat (3) @(negedge wb_clk);
                check_vec("abort_no_done", done, 0);
                return;
            end
            for (int j = 0; j < 3; j++) begin
                if (i == inject_at && j == 0) begin
                    latch = 1'b1;
                    go    = 1'b1;
                    p_in  = 32'hFFFF;
                end
                @(negedge wb_clk);
                latch = 1'b0;
                go    = 1'b0;
                if (done) done_cnt++;
            end
            if (done_cnt > 0 && !tip) finished = 1;
        end
        check_vec("xfer_completed", finished, 1);
    endtask

    initial begin
        repeat (3) @(negedge wb_clk);
        check_vec("rst_s_out", s_out, 0);
        check_vec("rst_p_out", p_out, 0);
        check_vec("rst_tip", tip, 0);
        check_vec("rst_done", done, 0);
        check_vec("rst_last", last, 0);
        wb_reset = 1'b0;

        // MSB-first mode 0 loopback
        load(32'hA5);
        run_xfer(8, 0, 1, 0, 0, 0, -1, 0);
        check_vec("t1_bits", cap, 64'hA5);
        check_vec("t1_p_out", p_out, 64'hA5);
        check_vec("t1_done_cnt", done_cnt, 1);
        check_vec("t1_tip_pos", pos_tip, 8);
        check_vec("t1_last_bad", last_bad, 0);
        repeat (5) @(negedge wb_clk);
        check_vec("t1_p_out_hold", p_out, 64'hA5);
        check_vec("t1_s_out_hold", s_out, 1);

        // LSB-first, MISO held high
        loop_en = 1'b0;
        s_hold  = 1'b1;
        load(32'h3);
        run_xfer(4, 1, 1, 0, 0, 0, -1, 0);
        check_vec("t2_bits", cap, 64'hC);
        check_vec("t2_p_out", p_out, 64'hF);
        check_vec("t2_last_bad", last_bad, 0);
        loop_en = 1'b1;

        // Full width, both edges on pos_edge
        load(32'hDEADBEEF);
        run_xfer(32, 0, 0, 0, 0, 0, -1, 0);
        check_vec("t3_bits", cap, 64'hDEADBEEF);
        check_vec("t3_p_out", p_out, 64'hDEADBEEF);
        check_vec("t3_tip_pos", pos_tip, 32);
        check_vec("t3_done_cnt", done_cnt, 1);

        // tx counter saturation: extra tx edge on the final sample must hold
        load(32'h1);
        run_xfer(4, 0, 0, 0, 0, 0, -1, 0);
        check_vec("t3b_bits", cap, 64'h1);
        check_vec("t3b_p_out", p_out, 64'h1);
        check_vec("t3b_s_out_sat", s_out, 1);

        // latch and go during a transfer are ignored
        load(32'hA5);
        run_xfer(8, 0, 1, 0, 0, 0, 5, 0);
        check_vec("t4_bits", cap, 64'hA5);
        check_vec("t4_p_out", p_out, 64'hA5);
        check_vec("t4_done_cnt", done_cnt, 1);
        repeat (10) @(negedge wb_clk);
        check_vec("t4_no_second_xfer", tip, 0);
        run_xfer(8, 0, 1, 0, 0, 0, -1, 0);
        check_vec("t4_shadow_kept", cap, 64'hA5);
        run_xfer(16, 0, 1, 0, 1, 32'hFFFF, -1, 0);
        check_vec("t4_ffff_bits", cap, 64'hFFFF);
        check_vec("t4_ffff_p_out", p_out, 64'hFFFF);

        // reset after 3 rx edges; shadow must also be cleared
        load(32'hA5);
        run_xfer(8, 0, 1, 0, 0, 0, -1, 3);
        run_xfer(8, 0, 1, 0, 0, 0, -1, 0);
        check_vec("t5_shadow_cleared", cap, 64'h0);
        check_vec("t5_done_cnt", done_cnt, 1);

        // same-edge tx/rx, latch together with go
        run_xfer(2, 0, 0, 0, 1, 32'h2, -1, 0);
        check_vec("t6_bits", cap, 64'h2);
        check_vec("t6_p_out", p_out, 64'h2);
        check_vec("t6_tip_pos", pos_tip, 2);
        check_vec("t6_done_cnt", done_cnt, 1);
        check_vec("t6_last_bad", last_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
